// File: rtl/trace_buffer.sv
// ---------------------------------------------------------------------------
// trace_buffer
//   Trace sink for the SoC trace port. Filters 64-bit trace words
//   {payload[31:0], timestamp[27:0], source_id[3:0]} by source ID and stores
//   them in a DEPTH-entry FIFO. Full behaviour is stop-when-full (drop new) or
//   circular (overwrite oldest). An optional trigger freezes capture POSTCNT
//   entries after a chosen source event so a debug host can drain the buffer.
//
// Ports
//   CLKF, MASRSTN        clock, async active-low reset
//   TP11, TPE11          trace word and its valid strobe
//   SRCMASK              per-source-ID accept mask
//   WRAP                 0 stop-when-full, 1 overwrite-oldest
//   ARM, CLR             start capture / synchronous clear
//   TRIGEN, TRIGSRC      trigger enable and trigger source ID
//   POSTCNT              entries stored after the trigger entry before freeze
//   RDREQ                pop one entry
//   RDATA, RVALID        registered pop data and its one-cycle valid
//   COUNT, EMPTY, FULL   occupancy
//   DROPCNT              saturating count of lost entries
//   STATE, TRIGGERED     capture state and sticky trigger flag
// ---------------------------------------------------------------------------
module trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLKF,
    input  logic          MASRSTN,
    input  logic [63:0]   TP11,
    input  logic          TPE11,
    input  logic [15:0]   SRCMASK,
    input  logic          WRAP,
    input  logic          ARM,
    input  logic          CLR,
    input  logic          TRIGEN,
    input  logic [3:0]    TRIGSRC,
    input  logic [AW:0]   POSTCNT,
    input  logic          RDREQ,
    output logic [63:0]   RDATA,
    output logic          RVALID,
    output logic [AW:0]   COUNT,
    output logic          EMPTY,
    output logic          FULL,
    output logic [7:0]    DROPCNT,
    output logic [1:0]    STATE,
    output logic          TRIGGERED
);

    localparam logic [1:0]    S_IDLE     = 2'b00;
    localparam logic [1:0]    S_CAPTURE  = 2'b01;
    localparam logic [1:0]    S_POSTTRIG = 2'b10;
    localparam logic [1:0]    S_FROZEN   = 2'b11;

    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, r_post;
    logic [7:0]    r_drop;
    logic [1:0]    r_state;
    logic          r_trig;
    logic [63:0]   r_rdata;
    logic          r_rvalid;

    logic w_full, w_empty, w_capturing, w_accept, w_rd;
    logic w_wr_norm, w_wr_ovw, w_drop, w_is_trig;

    assign w_full      = (r_count == CNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_capturing = (r_state == S_CAPTURE) || (r_state == S_POSTTRIG);
    assign w_accept    = TPE11 && SRCMASK[TP11[3:0]] && w_capturing;
    assign w_rd        = RDREQ && !w_empty;
    // A pop in the same cycle frees the slot, so a write while full still
    // stores normally when a read accompanies it.
    assign w_wr_norm   = w_accept && (!w_full || w_rd);
    assign w_wr_ovw    = w_accept && w_full && !w_rd && WRAP;
    // Both discarded and overwritten words count as lost.
    assign w_drop      = w_accept && w_full && !w_rd;
    assign w_is_trig   = w_accept && TRIGEN && (TP11[3:0] == TRIGSRC)
                         && (r_state == S_CAPTURE);

    // Storage is not reset; only pointers and counts are.
    always_ff @(posedge CLKF) begin
        if (!CLR && (w_wr_norm || w_wr_ovw))
            r_mem[r_wr_ptr] <= TP11;
    end

    always_ff @(posedge CLKF or negedge MASRSTN) begin
        if (!MASRSTN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else if (CLR) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd)
                r_rdata <= r_mem[r_rd_ptr];
            if (w_wr_norm || w_wr_ovw)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            // Overwrite pushes the oldest entry out, so rd_ptr follows.
            if (w_rd || w_wr_ovw)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_wr_norm && !w_rd)
                r_count <= r_count + CNT_ONE;
            else if (w_rd && !w_wr_norm)
                r_count <= r_count - CNT_ONE;
            if (w_drop && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
        end
    end

    always_ff @(posedge CLKF or negedge MASRSTN) begin
        if (!MASRSTN) begin
            r_state <= S_IDLE;
            r_trig  <= 1'b0;
            r_post  <= '0;
        end else if (CLR) begin
            r_state <= S_IDLE;
            r_trig  <= 1'b0;
            r_post  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_FROZEN: begin
                    if (ARM) begin
                        r_state <= S_CAPTURE;
                        r_trig  <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (w_is_trig) begin
                        r_trig <= 1'b1;
                        if (POSTCNT == '0) begin
                            r_state <= S_FROZEN;
                        end else begin
                            r_post  <= POSTCNT;
                            r_state <= S_POSTTRIG;
                        end
                    end
                end
                default: begin
                    // Counts every accepted word, stored or dropped.
                    if (w_accept) begin
                        r_post <= r_post - CNT_ONE;
                        if (r_post == CNT_ONE)
                            r_state <= S_FROZEN;
                    end
                end
            endcase
        end
    end

    assign RDATA     = r_rdata;
    assign RVALID    = r_rvalid;
    assign COUNT     = r_count;
    assign EMPTY     = w_empty;
    assign FULL      = w_full;
    assign DROPCNT   = r_drop;
    assign STATE     = r_state;
    assign TRIGGERED = r_trig;

endmodule

// File: tb/tb_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_trace_buffer
//   Directed bench for trace_buffer: a vector table for single-cycle
//   behaviour, then hand-written sequences for fill/drop, wrap, simultaneous
//   read/write when full, trigger/freeze and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_trace_buffer;

    logic        CLKF = 1'b0;
    logic        MASRSTN;
    logic [63:0] TP11;
    logic        TPE11, WRAP, ARM, CLR, TRIGEN, RDREQ;
    logic [15:0] SRCMASK;
    logic [3:0]  TRIGSRC;
    logic [4:0]  POSTCNT;
    logic [63:0] RDATA;
    logic        RVALID, EMPTY, FULL, TRIGGERED;
    logic [4:0]  COUNT;
    logic [7:0]  DROPCNT;
    logic [1:0]  STATE;

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] expq[$];

    trace_buffer #(.DEPTH(16), .AW(4)) dut (
        .CLKF(CLKF), .MASRSTN(MASRSTN), .TP11(TP11), .TPE11(TPE11),
        .SRCMASK(SRCMASK), .WRAP(WRAP), .ARM(ARM), .CLR(CLR),
        .TRIGEN(TRIGEN), .TRIGSRC(TRIGSRC), .POSTCNT(POSTCNT),
        .RDREQ(RDREQ), .RDATA(RDATA), .RVALID(RVALID), .COUNT(COUNT),
        .EMPTY(EMPTY), .FULL(FULL), .DROPCNT(DROPCNT), .STATE(STATE),
        .TRIGGERED(TRIGGERED)
    );

    always #5 CLKF = ~CLKF;

    typedef struct {
        bit          tpe;
        logic [3:0]  id;
        logic [31:0] pay;
        bit          rd;
        bit          arm;
        bit          clr;
        logic [4:0]  e_count;
        logic [1:0]  e_state;
        bit          e_rvalid;
        bit          chk_rd;
        logic [63:0] e_rdata;
    } vec_t;

    function automatic logic [63:0] mk(input logic [31:0] pay, input logic [3:0] id);
        return {pay, pay[27:0], id};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLKF);
        #1;
    endtask

    task automatic push(input logic [31:0] pay, input logic [3:0] id);
        TP11  = mk(pay, id);
        TPE11 = 1'b1;
        tick();
        TPE11 = 1'b0;
    endtask

    task automatic pulse_clr();
        CLR = 1'b1; tick(); CLR = 1'b0;
    endtask

    task automatic pulse_arm();
        ARM = 1'b1; tick(); ARM = 1'b0;
    endtask

    // Pops expq.size() entries back to back and compares each against expq.
    task automatic drain(input string nm);
        int n;
        n = expq.size();
        RDREQ = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == n - 1) RDREQ = 1'b0;
            chk({nm, " rvalid"}, 64'(RVALID), 64'd1);
            chk({nm, " rdata"}, RDATA, expq[i]);
        end
        tick();
        chk({nm, " rvalid end"}, 64'(RVALID), 64'd0);
        chk({nm, " empty end"}, 64'(EMPTY), 64'd1);
        expq.delete();
    endtask

    vec_t vt[12];

    initial begin
        MASRSTN = 1'b0; TP11 = '0; TPE11 = 0; WRAP = 0; ARM = 0; CLR = 0;
        TRIGEN = 0; RDREQ = 0; SRCMASK = 16'h0006; TRIGSRC = 4'd0; POSTCNT = '0;

        //        tpe id     pay   rd arm clr cnt st    rv chk rdata
        vt[0]  = '{1, 4'd1, 32'd1, 0, 0, 0, 5'd0, 2'b00, 0, 0, 64'd0};
        vt[1]  = '{0, 4'd0, 32'd0, 0, 1, 0, 5'd0, 2'b01, 0, 0, 64'd0};
        vt[2]  = '{1, 4'd1, 32'd2, 0, 0, 0, 5'd1, 2'b01, 0, 0, 64'd0};
        vt[3]  = '{1, 4'd5, 32'd3, 0, 0, 0, 5'd1, 2'b01, 0, 0, 64'd0};
        vt[4]  = '{1, 4'd0, 32'd4, 0, 0, 0, 5'd1, 2'b01, 0, 0, 64'd0};
        vt[5]  = '{1, 4'd2, 32'd5, 0, 0, 0, 5'd2, 2'b01, 0, 0, 64'd0};
        vt[6]  = '{0, 4'd0, 32'd0, 1, 0, 0, 5'd1, 2'b01, 1, 1, mk(32'd2, 4'd1)};
        vt[7]  = '{0, 4'd0, 32'd0, 1, 0, 0, 5'd0, 2'b01, 1, 1, mk(32'd5, 4'd2)};
        vt[8]  = '{0, 4'd0, 32'd0, 1, 0, 0, 5'd0, 2'b01, 0, 0, 64'd0};
        vt[9]  = '{1, 4'd2, 32'd9, 1, 0, 0, 5'd1, 2'b01, 0, 0, 64'd0};
        vt[10] = '{0, 4'd0, 32'd0, 0, 1, 0, 5'd1, 2'b01, 0, 0, 64'd0};
        vt[11] = '{1, 4'd2, 32'd11, 0, 1, 1, 5'd0, 2'b00, 0, 0, 64'd0};

        // Reset state
        #12;
        chk("rst rdata", RDATA, 64'd0);
        chk("rst rvalid", 64'(RVALID), 64'd0);
        chk("rst count", 64'(COUNT), 64'd0);
        chk("rst empty", 64'(EMPTY), 64'd1);
        chk("rst full", 64'(FULL), 64'd0);
        chk("rst drop", 64'(DROPCNT), 64'd0);
        chk("rst state", 64'(STATE), 64'd0);
        chk("rst trig", 64'(TRIGGERED), 64'd0);
        @(negedge CLKF);
        MASRSTN = 1'b1;

        // Table: filter, single reads, empty read, ARM in CAPTURE, CLR priority
        for (int i = 0; i < 12; i++) begin
            TP11 = mk(vt[i].pay, vt[i].id);
            TPE11 = vt[i].tpe; RDREQ = vt[i].rd; ARM = vt[i].arm; CLR = vt[i].clr;
            tick();
            TPE11 = 0; RDREQ = 0; ARM = 0; CLR = 0;
            chk($sformatf("vec%0d count", i), 64'(COUNT), 64'(vt[i].e_count));
            chk($sformatf("vec%0d empty", i), 64'(EMPTY), 64'(vt[i].e_count == 0));
            chk($sformatf("vec%0d state", i), 64'(STATE), 64'(vt[i].e_state));
            chk($sformatf("vec%0d rvalid", i), 64'(RVALID), 64'(vt[i].e_rvalid));
            if (vt[i].chk_rd)
                chk($sformatf("vec%0d rdata", i), RDATA, vt[i].e_rdata);
        end

        // Fill with WRAP=0: 20 words IDs 1/2 alternating, first 16 kept
        pulse_clr(); pulse_arm();
        SRCMASK = 16'h0006; WRAP = 0;
        for (int i = 0; i < 20; i++) push(32'(i), (i % 2 == 0) ? 4'd1 : 4'd2);
        chk("fill count", 64'(COUNT), 64'd16);
        chk("fill full", 64'(FULL), 64'd1);
        chk("fill drop", 64'(DROPCNT), 64'd4);
        for (int i = 0; i < 16; i++) expq.push_back(mk(32'(i), (i % 2 == 0) ? 4'd1 : 4'd2));
        drain("fill drain");

        // Wrap: 20 words, oldest 4 overwritten
        pulse_clr(); pulse_arm();
        SRCMASK = 16'hFFFF; WRAP = 1;
        for (int i = 0; i < 20; i++) push(32'(i), 4'd7);
        chk("wrap count", 64'(COUNT), 64'd16);
        chk("wrap drop", 64'(DROPCNT), 64'd4);
        for (int i = 4; i < 20; i++) expq.push_back(mk(32'(i), 4'd7));
        drain("wrap drain");

        // Simultaneous read+write while full, WRAP=0
        pulse_clr(); pulse_arm();
        WRAP = 0;
        for (int i = 0; i < 16; i++) push(32'(100 + i), 4'd4);
        chk("sim full", 64'(FULL), 64'd1);
        for (int j = 0; j < 10; j++) begin
            TP11 = mk(32'(200 + j), 4'd4); TPE11 = 1; RDREQ = 1;
            tick();
            chk($sformatf("sim%0d rvalid", j), 64'(RVALID), 64'd1);
            chk($sformatf("sim%0d rdata", j), RDATA, mk(32'(100 + j), 4'd4));
            chk($sformatf("sim%0d count", j), 64'(COUNT), 64'd16);
        end
        TPE11 = 0; RDREQ = 0;
        chk("sim drop", 64'(DROPCNT), 64'd0);
        for (int i = 10; i < 16; i++) expq.push_back(mk(32'(100 + i), 4'd4));
        for (int i = 0; i < 10; i++) expq.push_back(mk(32'(200 + i), 4'd4));
        drain("sim drain");

        // Trigger on ID 3 with 5 post entries; 9th word rejected
        pulse_clr(); pulse_arm();
        WRAP = 1; TRIGEN = 1; TRIGSRC = 4'd3; POSTCNT = 5'd5;
        for (int i = 0; i < 9; i++) begin
            push(32'(i), (i == 2) ? 4'd3 : 4'd1);
            if (i == 1) chk("trg pre", 64'(TRIGGERED), 64'd0);
            if (i == 2) begin
                chk("trg state post", 64'(STATE), 64'd2);
                chk("trg sticky", 64'(TRIGGERED), 64'd1);
            end
            if (i == 6) chk("trg not yet", 64'(STATE), 64'd2);
            if (i == 7) chk("trg frozen", 64'(STATE), 64'd3);
        end
        chk("trg count", 64'(COUNT), 64'd8);
        chk("trg still", 64'(TRIGGERED), 64'd1);
        // Re-ARM from FROZEN keeps data; POSTCNT=0 freezes on the trigger word
        pulse_arm();
        chk("rearm state", 64'(STATE), 64'd1);
        chk("rearm count", 64'(COUNT), 64'd8);
        chk("rearm trig", 64'(TRIGGERED), 64'd0);
        POSTCNT = 5'd0;
        push(32'd50, 4'd3);
        chk("pc0 state", 64'(STATE), 64'd3);
        chk("pc0 count", 64'(COUNT), 64'd9);
        push(32'd51, 4'd1);
        chk("pc0 reject", 64'(COUNT), 64'd9);
        for (int i = 0; i < 8; i++) expq.push_back(mk(32'(i), (i == 2) ? 4'd3 : 4'd1));
        expq.push_back(mk(32'd50, 4'd3));
        drain("trg drain");
        TRIGEN = 0;

        // Asynchronous reset mid-capture with COUNT=7
        pulse_clr(); pulse_arm();
        for (int i = 0; i < 8; i++) push(32'(300 + i), 4'd6);
        RDREQ = 1; tick(); RDREQ = 0;
        chk("ar count", 64'(COUNT), 64'd7);
        chk("ar rdata pre", RDATA, mk(32'd300, 4'd6));
        #2;
        MASRSTN = 1'b0;
        #1;
        chk("ar rdata", RDATA, 64'd0);
        chk("ar count0", 64'(COUNT), 64'd0);
        chk("ar empty", 64'(EMPTY), 64'd1);
        chk("ar full", 64'(FULL), 64'd0);
        chk("ar drop", 64'(DROPCNT), 64'd0);
        chk("ar state", 64'(STATE), 64'd0);
        chk("ar trig", 64'(TRIGGERED), 64'd0);
        @(negedge CLKF);
        MASRSTN = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) push(32'(400 + i), 4'd6);
        chk("ar noarm count", 64'(COUNT), 64'd0);
        chk("ar noarm state", 64'(STATE), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
